// File: rtl/onehot_decoder_pkg.sv
// Shared types for the one-hot decoder sequencer: command modes and FSM states.
package onehot_decoder_pkg;

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        BUSY_DIRECT = 2'd1,
        BUSY_SCAN   = 2'd2
    } state_e;

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational index-to-one-hot converter; any index >= NUM_OUT yields all zeros.
module onehot_dec_core #(
    parameter int IN_W    = 5,
    parameter int NUM_OUT = 2**IN_W
) (
    input  logic [IN_W-1:0]    index,
    output logic [NUM_OUT-1:0] onehot
);

    // Comparing against every legal position keeps out-of-range indices at zero
    // without relying on shift truncation behaviour.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (index == IN_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequenced one-hot decoder: DIRECT emits one decoded beat, SCAN walks a single
// one from bit 0 up to a (clamped) end index, one beat per output handshake.
module onehot_decoder_seq
    import onehot_decoder_pkg::*;
#(
    parameter int IN_W    = 5,
    parameter int NUM_OUT = 2**IN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    output logic               ready_in,
    input  logic               mode_in,
    input  logic [IN_W-1:0]    data_in,
    output logic               valid_out,
    input  logic               ready_out,
    output logic [NUM_OUT-1:0] data_out,
    output logic [IN_W-1:0]    index_out,
    output logic               last_out,
    output logic               err_out
);

    // One extra bit so that NUM_OUT == 2**IN_W is representable in the compare.
    localparam logic [IN_W:0]   NUM_OUT_EXT = (IN_W+1)'(NUM_OUT);
    localparam logic [IN_W-1:0] MAX_IDX     = IN_W'(NUM_OUT - 1);

    state_e              state, state_nxt;
    logic [IN_W-1:0]     scan_cnt, scan_cnt_nxt;
    logic [IN_W-1:0]     scan_end, scan_end_nxt;
    logic [IN_W-1:0]     scan_inc;
    logic [IN_W-1:0]     idx_nxt;
    logic                last_nxt;
    logic                err_nxt;
    logic                valid_nxt;
    logic                beat_upd;
    logic                accept;
    logic                in_range;
    logic [IN_W-1:0]     clamped_end;
    logic [NUM_OUT-1:0]  onehot;

    assign ready_in    = (state == IDLE) || ((state == BUSY_DIRECT) && ready_out);
    assign accept      = valid_in && ready_in;
    assign in_range    = ({1'b0, data_in} < NUM_OUT_EXT);
    assign clamped_end = in_range ? data_in : MAX_IDX;
    assign scan_inc    = scan_cnt + 1'b1;

    onehot_dec_core #(
        .IN_W    (IN_W),
        .NUM_OUT (NUM_OUT)
    ) u_core (
        .index  (idx_nxt),
        .onehot (onehot)
    );

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        valid_nxt    = valid_out;
        scan_cnt_nxt = scan_cnt;
        scan_end_nxt = scan_end;
        idx_nxt      = index_out;
        last_nxt     = last_out;
        err_nxt      = err_out;
        beat_upd     = 1'b0;

        case (state)
            BUSY_DIRECT: begin
                if (ready_out) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            BUSY_SCAN: begin
                if (ready_out) begin
                    if (last_out) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end else begin
                        scan_cnt_nxt = scan_inc;
                        idx_nxt      = scan_inc;
                        last_nxt     = (scan_inc == scan_end);
                        beat_upd     = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        // A new command overrides retirement of the previous DIRECT beat.
        if (accept) begin
            valid_nxt = 1'b1;
            err_nxt   = !in_range;
            beat_upd  = 1'b1;
            if (mode_e'(mode_in) == SCAN) begin
                state_nxt    = BUSY_SCAN;
                scan_cnt_nxt = '0;
                scan_end_nxt = clamped_end;
                idx_nxt      = '0;
                last_nxt     = (clamped_end == '0);
            end else begin
                state_nxt = BUSY_DIRECT;
                idx_nxt   = data_in;
                last_nxt  = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            data_out  <= '0;
            index_out <= '0;
            last_out  <= 1'b0;
            err_out   <= 1'b0;
            scan_cnt  <= '0;
            scan_end  <= '0;
        end else begin
            state     <= state_nxt;
            valid_out <= valid_nxt;
            scan_cnt  <= scan_cnt_nxt;
            scan_end  <= scan_end_nxt;
            // Beat fields only move on a new beat, so they hold through stalls.
            if (beat_upd) begin
                data_out  <= onehot;
                index_out <= idx_nxt;
                last_out  <= last_nxt;
                err_out   <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: default 32-output instance plus a
// NUM_OUT=20 instance for range clamping.
module tb_onehot_decoder_seq;

    logic        clk;
    logic        rst_n;

    logic        valid_in, ready_in, mode_in, valid_out, ready_out, last_out, err_out;
    logic [4:0]  data_in, index_out;
    logic [31:0] data_out;

    logic        valid_in2, ready_in2, mode_in2, valid_out2, ready_out2, last_out2, err_out2;
    logic [4:0]  data_in2, index_out2;
    logic [19:0] data_out2;

    int checks = 0;
    int errors = 0;

    onehot_decoder_seq u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .mode_in   (mode_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .index_out (index_out),
        .last_out  (last_out),
        .err_out   (err_out)
    );

    onehot_decoder_seq #(.IN_W(5), .NUM_OUT(20)) u_dut20 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in2),
        .ready_in  (ready_in2),
        .mode_in   (mode_in2),
        .data_in   (data_in2),
        .valid_out (valid_out2),
        .ready_out (ready_out2),
        .data_out  (data_out2),
        .index_out (index_out2),
        .last_out  (last_out2),
        .err_out   (err_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0; mode_in = 1'b0; data_in = '0; ready_out = 1'b0;
        valid_in2 = 1'b0; mode_in2 = 1'b0; data_in2 = '0; ready_out2 = 1'b0;
        step();
        step();
        checks++;
        if ({valid_out, data_out, index_out, last_out, err_out} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b d=%h i=%0d l=%0b e=%0b expected all zero",
                     valid_out, data_out, index_out, last_out, err_out);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_in: got %0b expected 1", ready_in);
        end
        step();
        checks++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got valid_out=%0b ready_in=%0b expected 0/1", valid_out, ready_in);
        end
    endtask

    task automatic test_direct();
        valid_in = 1'b1; mode_in = 1'b0; data_in = 5'd0; ready_out = 1'b1;
        step();
        valid_in = 1'b0;
        checks++;
        if ({valid_out, data_out, index_out, last_out, err_out} !== {1'b1, 32'h00000001, 5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL direct_zero: got v=%0b d=%h i=%0d l=%0b e=%0b expected 1/00000001/0/1/0",
                     valid_out, data_out, index_out, last_out, err_out);
        end
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL direct_retire: got valid_out=%0b expected 0", valid_out);
        end
    endtask

    task automatic test_back_to_back();
        valid_in = 1'b1; mode_in = 1'b0; data_in = 5'd31; ready_out = 1'b1;
        #1;
        checks++;
        if (ready_in !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_first: got %0b expected 1", ready_in);
        end
        step();
        data_in = 5'd4;
        #1;
        checks++;
        if (data_out !== 32'h80000000 || index_out !== 5'd31 || valid_out !== 1'b1 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL b2b_beat31: got d=%h i=%0d v=%0b rdy=%0b expected 80000000/31/1/1",
                     data_out, index_out, valid_out, ready_in);
        end
        step();
        valid_in = 1'b0;
        #1;
        checks++;
        if (data_out !== 32'h00000010 || index_out !== 5'd4 || valid_out !== 1'b1 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL b2b_beat4: got d=%h i=%0d v=%0b rdy=%0b expected 00000010/4/1/1",
                     data_out, index_out, valid_out, ready_in);
        end
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_retire: got valid_out=%0b expected 0", valid_out);
        end
    endtask

    task automatic test_scan_stall();
        logic        pattern [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          exp_idx = 0;
        logic [31:0] exp_data;
        valid_in = 1'b1; mode_in = 1'b1; data_in = 5'd3; ready_out = 1'b1;
        step();
        valid_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ready_out = pattern[k];
            #1;
            exp_data = 32'd1 << exp_idx;
            checks++;
            if (valid_out !== 1'b1 || data_out !== exp_data || index_out !== 5'(exp_idx)
                || last_out !== (exp_idx == 3) || err_out !== 1'b0 || ready_in !== 1'b0) begin
                errors++;
                $display("FAIL scan_beat[%0d]: got v=%0b d=%h i=%0d l=%0b e=%0b rdy=%0b expected 1/%h/%0d/%0b/0/0",
                         k, valid_out, data_out, index_out, last_out, err_out, ready_in,
                         exp_data, exp_idx, (exp_idx == 3));
            end
            step();
            if (pattern[k]) exp_idx++;
        end
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL scan_done: got valid_out=%0b ready_in=%0b expected 0/1", valid_out, ready_in);
        end
    endtask

    task automatic test_num_out20();
        logic [19:0] exp_data;
        valid_in2 = 1'b1; mode_in2 = 1'b0; data_in2 = 5'd25; ready_out2 = 1'b1;
        step();
        valid_in2 = 1'b0;
        checks++;
        if ({valid_out2, data_out2, index_out2, last_out2, err_out2} !== {1'b1, 20'h00000, 5'd25, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL n20_direct_err: got v=%0b d=%h i=%0d l=%0b e=%0b expected 1/00000/25/1/1",
                     valid_out2, data_out2, index_out2, last_out2, err_out2);
        end
        step();
        valid_in2 = 1'b1; mode_in2 = 1'b1; data_in2 = 5'd25;
        step();
        valid_in2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_data = 20'd1 << i;
            checks++;
            if (valid_out2 !== 1'b1 || data_out2 !== exp_data || index_out2 !== 5'(i)
                || last_out2 !== (i == 19) || err_out2 !== 1'b1) begin
                errors++;
                $display("FAIL n20_scan_beat[%0d]: got v=%0b d=%h i=%0d l=%0b e=%0b expected 1/%h/%0d/%0b/1",
                         i, valid_out2, data_out2, index_out2, last_out2, err_out2, exp_data, i, (i == 19));
            end
            step();
        end
        checks++;
        if (valid_out2 !== 1'b0) begin
            errors++;
            $display("FAIL n20_scan_done: got valid_out=%0b expected 0", valid_out2);
        end
        ready_out2 = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int seen_valid = 0;
        valid_in = 1'b1; mode_in = 1'b1; data_in = 5'd10; ready_out = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (index_out !== 5'd5 || data_out !== 32'h00000020 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got i=%0d d=%h v=%0b expected 5/00000020/1", index_out, data_out, valid_out);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_out, data_out, index_out, last_out, err_out} !== 40'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got v=%0b d=%h i=%0d l=%0b e=%0b expected all zero",
                     valid_out, data_out, index_out, last_out, err_out);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_in !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: got ready_in=%0b expected 1", ready_in);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid_out !== 1'b0) seen_valid++;
        end
        checks++;
        if (seen_valid !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_beats: got %0d valid cycles expected 0", seen_valid);
        end
    endtask

    task automatic test_scan_zero();
        valid_in = 1'b1; mode_in = 1'b1; data_in = 5'd0; ready_out = 1'b1;
        step();
        valid_in = 1'b0;
        checks++;
        if ({valid_out, data_out, index_out, last_out, err_out} !== {1'b1, 32'h00000001, 5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL scan0_beat: got v=%0b d=%h i=%0d l=%0b e=%0b expected 1/00000001/0/1/0",
                     valid_out, data_out, index_out, last_out, err_out);
        end
        step();
        checks++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL scan0_idle: got valid_out=%0b ready_in=%0b expected 0/1", valid_out, ready_in);
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_back_to_back();
        test_scan_stall();
        test_num_out20();
        test_reset_mid_scan();
        test_scan_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_seq.md
ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 Parameter IN_W, default 5, select index width in bits.
REQ-002 Parameter NUM_OUT, default 2**IN_W, one-hot output width; legal range 2..2**IN_W.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Valid_in  input  1  command valid.
REQ-006 Ready_in  output  1  command accepted when Valid_in && Ready_in.
REQ-007 Mode_in  input  1  0 = DIRECT (single decode), 1 = SCAN (walking-one sequence).
REQ-008 Data_in  input  IN_W  decode index (DIRECT) or scan end index (SCAN).
REQ-009 Valid_out  output  1  output beat valid.
REQ-010 Ready_out  input  1  downstream accepts beat when Valid_out && Ready_out.
REQ-011 Data_out  output  NUM_OUT  one-hot decoded word, or all-zero on error.
REQ-012 Index_out  output  IN_W  binary index matching Data_out.
REQ-013 Last_out  output  1  final beat of the current command.
REQ-014 Err_out  output  1  index was out of range (>= NUM_OUT).

Function
REQ-015 FSM states: IDLE, BUSY_DIRECT, BUSY_SCAN; encoding from the shared package.
REQ-016 Ready_in SHALL be high in IDLE, and in BUSY_DIRECT when Ready_out is high (allowing back-to-back DIRECT); low in BUSY_SCAN.
REQ-017 DIRECT accept: next cycle Valid_out=1, Data_out bit Data_in set, all other bits 0, Index_out=Data_in, Last_out=1, Err_out=0; latency 1 cycle.
REQ-018 DIRECT with Data_in >= NUM_OUT: Data_out=0, Index_out=Data_in, Last_out=1, Err_out=1.
REQ-019 SCAN accept with end index E: beats for indices 0,1,...,E in order, one per output handshake; first beat valid the cycle after acceptance.
REQ-020 SCAN with E >= NUM_OUT: end index clamped to NUM_OUT-1; Err_out=1 on every beat of that command.
REQ-021 Last_out high only on the beat with index = (clamped) end index; SCAN with E=0 yields exactly one beat with Last_out=1.
REQ-022 Output stall: while Valid_out && !Ready_out, Data_out, Index_out, Last_out, Err_out SHALL hold stable; scan counter SHALL not advance.
REQ-023 Last-beat handshake in SCAN returns FSM to IDLE; Valid_out drops next cycle unless a new command is accepted in that cycle (Ready_in high on the cycle after, not the same cycle).
REQ-024 Valid_out SHALL never rise without a prior accepted command; outputs never change while stalled.
REQ-025 Data_out SHALL always be one-hot or all-zero; never multi-hot.

Reset
REQ-026 Rst_n low SHALL immediately force: FSM=IDLE, Valid_out=0, Data_out=0, Index_out=0, Last_out=0, Err_out=0, scan counter=0, independent of Clk.
REQ-027 Reset mid-SCAN SHALL abandon the sequence; no remaining beats emitted after release.
REQ-028 Ready_in SHALL be high on the first clock after Rst_n deasserts.

Structure
REQ-029 Package onehot_decoder_pkg SHALL hold the mode enum (DIRECT/SCAN) and FSM state enum.
REQ-030 Index-to-one-hot conversion SHALL be a combinational sub-module onehot_dec_core (params IN_W, NUM_OUT; outputs zero for out-of-range index), instantiated once.
REQ-031 Scan counter width IN_W; clamp and compare logic sized so NUM_OUT=2**IN_W never overflows.

Verification
REQ-032 DIRECT Data_in=5'd0, Ready_out=1 -> next cycle Data_out=32'h00000001, Index_out=0, Last_out=1, Err_out=0.
REQ-033 DIRECT back-to-back 5'd31 then 5'd4, Ready_out=1 -> 32'h80000000 then 32'h00000010 on consecutive cycles, Ready_in never low.
REQ-034 SCAN Data_in=5'd3, Ready_out toggling 1,0,1,1,0,1 -> beats 32'h1, 32'h2, 32'h4, 32'h8 in order, held during stalls, Last_out only with 32'h8, Ready_in low throughout.
REQ-035 NUM_OUT=20: DIRECT Data_in=5'd25 -> Data_out=0, Err_out=1; SCAN Data_in=5'd25 -> 20 beats ending 20'h80000 with Last_out=1, Err_out=1 each beat.
REQ-036 Rst_n pulsed low mid-clock during SCAN Data_in=5'd10 at beat 5 -> outputs zero immediately, no further beats, Ready_in=1 first clock after release.
REQ-037 SCAN Data_in=5'd0 -> single beat 32'h00000001 with Last_out=1, FSM IDLE next cycle.
